// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide memory (separate read/write address, single write
// strobe) between the cpu (port A) and a host/loader port (port B). Single-byte
// transactions are serialised and granted round-robin. The host can assert
// b_lock to keep port A out entirely, e.g. during program load or a register
// dump.
//
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata -> a_rdata/a_ack   cpu request port
//   b_req/b_we/b_addr/b_wdata -> b_rdata/b_ack   host request port
//   b_lock              while high, port A is never granted
//   grant_a, grant_b    owner of the transaction in flight
//   mem_raddr, mem_waddr, mem_data_in, mem_write   memory side
//   mem_data_out        memory read data, valid the cycle after mem_raddr
//
// Timing, counted from the edge that samples req in IDLE:
//   read : RWAIT(1) RCAP(2) DONE/ack(3) IDLE(4)
//   write: WDONE/mem_write(1) DONE/ack(2) IDLE(3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [7:0]            a_wdata,
    output logic [7:0]            a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [7:0]            b_wdata,
    output logic [7:0]            b_rdata,
    output logic                  b_ack,
    input  logic                  b_lock,
    output logic                  grant_a,
    output logic                  grant_b,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RWAIT = 3'd1,
        RCAP  = 3'd2,
        WDONE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;            // 0 = A, 1 = B
    logic                  last_owner_q, last_owner_d;  // 0 = A, 1 = B
    logic [7:0]            a_rdata_q, a_rdata_d;
    logic [7:0]            b_rdata_q, b_rdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic                  grant_a_q, grant_a_d;
    logic                  grant_b_q, grant_b_d;
    logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
    logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]            mem_data_in_q, mem_data_in_d;
    logic                  mem_write_q, mem_write_d;

    // Request selection, only consulted in IDLE.
    logic                  a_elig;
    logic                  b_elig;
    logic                  sel_b;
    logic                  sel_we;
    logic [addr_width-1:0] sel_addr;
    logic [7:0]            sel_wdata;

    assign a_elig    = a_req & ~b_lock;
    assign b_elig    = b_req;
    // On a tie the port that did not own the previous transaction wins.
    assign sel_b     = (a_elig & b_elig) ? ~last_owner_q : b_elig;
    assign sel_we    = sel_b ? b_we    : a_we;
    assign sel_addr  = sel_b ? b_addr  : a_addr;
    assign sel_wdata = sel_b ? b_wdata : a_wdata;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        a_rdata_d     = a_rdata_q;
        b_rdata_d     = b_rdata_q;
        a_ack_d       = a_ack_q;
        b_ack_d       = b_ack_q;
        grant_a_d     = grant_a_q;
        grant_b_d     = grant_b_q;
        mem_raddr_d   = mem_raddr_q;
        mem_waddr_d   = mem_waddr_q;
        mem_data_in_d = mem_data_in_q;
        mem_write_d   = mem_write_q;

        case (state_q)
            IDLE: begin
                if (a_elig | b_elig) begin
                    owner_d      = sel_b;
                    last_owner_d = sel_b;
                    grant_a_d    = ~sel_b;
                    grant_b_d    = sel_b;
                    if (sel_we) begin
                        mem_waddr_d   = sel_addr;
                        mem_data_in_d = sel_wdata;
                        mem_write_d   = 1'b1;
                        state_d       = WDONE;
                    end else begin
                        mem_raddr_d   = sel_addr;
                        state_d       = RWAIT;
                    end
                end
            end
            RWAIT: begin
                // Memory read latency; outputs unchanged.
                state_d = RCAP;
            end
            RCAP: begin
                if (owner_q) begin
                    b_rdata_d = mem_data_out;
                    b_ack_d   = 1'b1;
                end else begin
                    a_rdata_d = mem_data_out;
                    a_ack_d   = 1'b1;
                end
                state_d = DONE;
            end
            WDONE: begin
                mem_write_d = 1'b0;
                if (owner_q) begin
                    b_ack_d = 1'b1;
                end else begin
                    a_ack_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                // No request is sampled here, so a req still high during the
                // ack cycle cannot start a duplicate transaction.
                a_ack_d   = 1'b0;
                b_ack_d   = 1'b0;
                grant_a_d = 1'b0;
                grant_b_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;  // B, so A wins the first tie
            a_rdata_q     <= '0;
            b_rdata_q     <= '0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            grant_a_q     <= 1'b0;
            grant_b_q     <= 1'b0;
            mem_raddr_q   <= '0;
            mem_waddr_q   <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            a_rdata_q     <= a_rdata_d;
            b_rdata_q     <= b_rdata_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            grant_a_q     <= grant_a_d;
            grant_b_q     <= grant_b_d;
            mem_raddr_q   <= mem_raddr_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign grant_a     = grant_a_q;
    assign grant_b     = grant_b_q;
    assign mem_raddr   = mem_raddr_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Random two-port traffic against mem_arbiter. A byte memory with one cycle of
// read latency sits behind the arbiter. A transaction-level reference model
// (round-robin winner choice, fixed read/write occupancy, reference memory
// contents) predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_wdata, b_wdata;
    logic [7:0]    a_rdata, b_rdata;
    logic          a_ack, b_ack, grant_a, grant_b;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [7:0]    mem_data_in, mem_data_out;
    logic          mem_write;

    always #5 clk = ~clk;

    mem_arbiter #(.addr_width(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .b_lock(b_lock), .grant_a(grant_a), .grant_b(grant_b),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out)
    );

    // ---------------- memory behind the arbiter ----------------
    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 13 + 90) & 255);
    endfunction

    logic [7:0] env_mem [512];
    logic       env_written [512];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 512; i++) env_written[i] <= 1'b0;
        end else if (mem_write) begin
            env_mem[mem_waddr]     <= mem_data_in;
            env_written[mem_waddr] <= 1'b1;
        end
        mem_data_out <= env_written[mem_raddr] ? env_mem[mem_raddr]
                                               : init_val(int'(mem_raddr));
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    ref_mem [512];
    int            m_t;        // cycles into current transaction, 0 = idle
    int            m_occ;      // 4 for a read, 3 for a write
    bit            m_port;     // 0 = A, 1 = B
    bit            m_we;
    bit            m_last;     // last granted port
    logic [AW-1:0] m_addr;
    logic [7:0]    exp_rdata [2];
    logic [AW-1:0] exp_raddr, exp_waddr;
    logic [7:0]    exp_din;
    int            n_txn [2];

    // ---------------- per-port drivers ----------------
    bit            pend [2];
    bit            t_we [2];
    logic [AW-1:0] t_addr [2];
    logic [7:0]    t_wdata [2];

    task automatic apply_inputs(input int lock_mode);
        a_req = pend[0]; a_we = t_we[0]; a_addr = t_addr[0]; a_wdata = t_wdata[0];
        b_req = pend[1]; b_we = t_we[1]; b_addr = t_addr[1]; b_wdata = t_wdata[1];
        if (lock_mode == 1)      b_lock = 1'b1;
        else if (lock_mode == 2) b_lock = 1'b0;
        else if ($urandom_range(99) < 10) b_lock = ~b_lock;
    endtask

    task automatic new_txn(input int p, input int wr_pct);
        pend[p]    = 1'b1;
        t_we[p]    = ($urandom_range(99) < wr_pct);
        t_addr[p]  = $urandom_range(1) ? AW'($urandom_range(7)) : AW'($urandom_range(511));
        t_wdata[p] = 8'($urandom);
    endtask

    task automatic model_reset();
        m_t = 0; m_occ = 0; m_port = 0; m_we = 0; m_last = 1; m_addr = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_raddr = '0; exp_waddr = '0; exp_din = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; t_we[p] = 0; t_addr[p] = '0; t_wdata[p] = '0;
        end
    endtask

    // Advance the model across one rising edge using the present inputs.
    task automatic model_edge();
        bit a_el, b_el;
        if (m_t == 0) begin
            a_el = a_req && !b_lock;
            b_el = b_req;
            if (a_el || b_el) begin
                m_port = (a_el && b_el) ? !m_last : b_el;
                m_last = m_port;
                m_we   = m_port ? b_we : a_we;
                m_addr = m_port ? b_addr : a_addr;
                m_occ  = m_we ? 3 : 4;
                m_t    = 1;
                n_txn[m_port]++;
                if (m_we) begin
                    exp_waddr       = m_addr;
                    exp_din         = m_port ? b_wdata : a_wdata;
                    ref_mem[m_addr] = exp_din;
                end else begin
                    exp_raddr = m_addr;
                end
            end
        end else begin
            m_t++;
            if (!m_we && m_t == m_occ - 1) exp_rdata[m_port] = ref_mem[m_addr];
            if (m_t == m_occ) m_t = 0;
        end
    endtask

    function automatic bit exp_ack(input bit p);
        return (m_t != 0) && (m_t == m_occ - 1) && (m_port == p);
    endfunction

    task automatic check_outputs();
        check_eq("grant_a",     32'(grant_a),     32'((m_t != 0) && !m_port));
        check_eq("grant_b",     32'(grant_b),     32'((m_t != 0) && m_port));
        check_eq("a_ack",       32'(a_ack),       32'(exp_ack(1'b0)));
        check_eq("b_ack",       32'(b_ack),       32'(exp_ack(1'b1)));
        check_eq("mem_write",   32'(mem_write),   32'((m_t == 1) && m_we));
        check_eq("a_rdata",     32'(a_rdata),     32'(exp_rdata[0]));
        check_eq("b_rdata",     32'(b_rdata),     32'(exp_rdata[1]));
        check_eq("mem_raddr",   32'(mem_raddr),   32'(exp_raddr));
        check_eq("mem_waddr",   32'(mem_waddr),   32'(exp_waddr));
        check_eq("mem_data_in", 32'(mem_data_in), 32'(exp_din));
    endtask

    // One clock: predict, clock, compare, then update the port drivers.
    task automatic step(input int start_pct, input int keep_pct, input int wr_pct,
                        input bit a_en, input bit b_en, input int lock_mode);
        bit ack_e [2];
        bit en [2];
        en[0] = a_en; en[1] = b_en;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        for (int p = 0; p < 2; p++) begin
            ack_e[p] = exp_ack(1'(p));
            if (pend[p] && ack_e[p]) begin
                if ($urandom_range(99) < keep_pct) new_txn(p, wr_pct);
                else pend[p] = 1'b0;
            end else if (!pend[p] && en[p] && $urandom_range(99) < start_pct) begin
                new_txn(p, wr_pct);
            end
        end
        apply_inputs(lock_mode);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit hit;
        n_txn[0] = 0; n_txn[1] = 0;
        reset = 1'b0; b_lock = 1'b0;
        model_reset();
        apply_inputs(2);
        repeat (3) @(posedge clk);
        #1;
        check_outputs();                       // reset state
        @(negedge clk);
        reset = 1'b1;

        // Both ports read continuously from reset: A, B, A, B ...
        for (int i = 0; i < 40; i++) step(100, 100, 0, 1, 1, 2);
        check_eq("rr_balance", 32'(n_txn[0] - n_txn[1] + 1), 32'(1) + 32'(n_txn[0] > n_txn[1]));

        // Host lock with both ports writing: A must not be served.
        for (int i = 0; i < 40; i++) step(100, 100, 100, 1, 1, 1);
        for (int i = 0; i < 30; i++) step(100, 0, 50, 1, 1, 2);

        // A alone keeps req high after each ack.
        for (int i = 0; i < 30; i++) step(100, 100, 0, 1, 0, 2);

        // Mixed random traffic with random lock.
        for (int i = 0; i < 2000; i++) step(40, 30, 50, 1, 1, 0);

        // Reset in the middle of a write.
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(100, 0, 100, 1, 1, 2);
            hit = (m_t == 1) && m_we;
        end
        check_eq("rst_wait", 32'(hit), 32'(1));
        reset = 1'b0;
        #1;
        check_eq("rst_mem_write", 32'(mem_write), 32'(0));
        check_eq("rst_grant_a",   32'(grant_a),   32'(0));
        check_eq("rst_grant_b",   32'(grant_b),   32'(0));
        check_eq("rst_a_ack",     32'(a_ack),     32'(0));
        check_eq("rst_b_ack",     32'(b_ack),     32'(0));
        model_reset();
        apply_inputs(2);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fresh traffic after reset.
        for (int i = 0; i < 400; i++) step(40, 30, 50, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
